// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: data-memory handshake, stall, branch resolve, WB bundle.
// Define MEM_WB_STALL_COUNT_EN to add a saturating stall-cycle counter (stall_cycles/stall_count_clr).
module mem_wb_stage #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ex_branch_ne,
  input  logic         ex_branch_eq,
  input  logic         ex_jump,
  input  logic         ex_mem_read,
  input  logic         ex_mem_write,
  input  logic         ex_reg_write,
  input  logic         ex_mem_to_reg,
  input  logic         ex_zero,
  input  logic [N-1:0] ex_pc,
  input  logic [N-1:0] ex_alu_result,
  input  logic [N-1:0] ex_read_data2,
  input  logic [4:0]   ex_write_register,
  input  logic [N-1:0] ex_pc_4,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [N-1:0] dmem_addr,
  output logic [N-1:0] dmem_wdata,
  input  logic [N-1:0] dmem_rdata,
  input  logic         dmem_ack,
`ifdef MEM_WB_STALL_COUNT_EN
  input  logic         stall_count_clr,
  output logic [15:0]  stall_cycles,
`endif
  output logic         stall,
  output logic         pc_src,
  output logic [N-1:0] pc_target,
  output logic         flush,
  output logic         wb_reg_write,
  output logic         wb_mem_to_reg,
  output logic [N-1:0] wb_read_data,
  output logic [N-1:0] wb_alu_result,
  output logic [4:0]   wb_write_register,
  output logic [N-1:0] wb_pc_4
);

  typedef enum logic {StIdle, StWait} state_e;

  state_e state_q, state_d;
  logic   mem_op;
  logic   req_raw;
  logic   taken;

  logic         wb_reg_write_q, wb_mem_to_reg_q;
  logic [N-1:0] wb_read_data_q, wb_alu_result_q, wb_pc_4_q;
  logic [4:0]   wb_write_register_q;

  assign mem_op = ex_mem_read | ex_mem_write;

  always_comb begin
    state_d = state_q;
    req_raw = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_raw = mem_op;
        if (mem_op && !dmem_ack) state_d = StWait;
      end
      StWait: begin
        req_raw = 1'b1;
        if (dmem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Request is dropped for the whole reset window, abandoning any outstanding access.
  assign dmem_req   = req_raw & reset;
  assign dmem_we    = dmem_req & ex_mem_write;
  assign dmem_addr  = ex_alu_result;
  assign dmem_wdata = ex_read_data2;
  assign stall      = dmem_req & ~dmem_ack;

  // Stall has priority over a (never legal) coincident branch.
  assign taken     = (ex_branch_eq & ex_zero) | (ex_branch_ne & ~ex_zero) | ex_jump;
  assign pc_src    = taken & ~stall;
  assign flush     = pc_src;
  assign pc_target = ex_pc;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      wb_reg_write_q      <= 1'b0;
      wb_mem_to_reg_q     <= 1'b0;
      wb_read_data_q      <= '0;
      wb_alu_result_q     <= '0;
      wb_write_register_q <= '0;
      wb_pc_4_q           <= '0;
    end else if (stall) begin
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
    end else begin
      wb_reg_write_q      <= ex_reg_write;
      wb_mem_to_reg_q     <= ex_mem_to_reg;
      wb_read_data_q      <= (ex_mem_read && dmem_ack) ? dmem_rdata : '0;
      wb_alu_result_q     <= ex_alu_result;
      wb_write_register_q <= ex_write_register;
      wb_pc_4_q           <= ex_pc_4;
    end
  end

  assign wb_reg_write      = wb_reg_write_q;
  assign wb_mem_to_reg     = wb_mem_to_reg_q;
  assign wb_read_data      = wb_read_data_q;
  assign wb_alu_result     = wb_alu_result_q;
  assign wb_write_register = wb_write_register_q;
  assign wb_pc_4           = wb_pc_4_q;

`ifdef MEM_WB_STALL_COUNT_EN
  logic [15:0] stall_cycles_q;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
    end else if (stall_count_clr) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule
